// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared state and reset-cause encodings for reset_sequencer
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    localparam logic [1:0] CAUSE_POR = 2'd0;
    localparam logic [1:0] CAUSE_EXT = 2'd1;
    localparam logic [1:0] CAUSE_WDT = 2'd2;

endpackage

// File: rtl/reset_sync_debounce.sv
// rtl/reset_sync_debounce.sv - 2-FF synchronizer, saturating debounce and one-shot accept for rst_req
module reset_sync_debounce #(
    parameter int DEB_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic rst_req,
    output logic accept
);

    localparam logic [DEB_W-1:0] DEB_LAST = '1;

    logic             sync_q1  = 1'b0;
    logic             sync_q2  = 1'b0;
    logic [DEB_W-1:0] deb_cnt  = '0;
    logic             armed    = 1'b1;
    logic             accept_q = 1'b0;
    logic             fire;

    // Fires on the first cycle the level is seen with the counter already saturated,
    // so the request must have persisted 2^DEB_W synchronized cycles.
    assign fire   = sync_q2 && (deb_cnt == DEB_LAST) && armed;
    assign accept = accept_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            deb_cnt  <= '0;
            armed    <= 1'b1;
            accept_q <= 1'b0;
        end else begin
            sync_q1  <= rst_req;
            sync_q2  <= sync_q1;
            accept_q <= fire;
            if (!sync_q2) begin
                deb_cnt <= '0;
                armed   <= 1'b1;
            end else begin
                if (deb_cnt != DEB_LAST) begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
                if (fire) begin
                    armed <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release with debounced request; watchdog under RESET_SEQ_WDT_EN
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int N_STAGES  = 2,
    parameter int STAGE_GAP = 16,
    parameter int DEB_W     = 4,
    parameter int WDT_W     = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rst_req,
    input  logic                wdt_en,
    input  logic                wdt_kick,
    output logic [N_STAGES-1:0] rst_out,
    output logic                ready,
    output logic [1:0]          rst_cause
);

    localparam int                GAP_W      = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = '1;
    localparam logic [3:0]        STAGE_LAST = 4'(N_STAGES);

    seq_state_t          state     = HOLD;
    logic [CNT_W-1:0]    hold_cnt  = '0;
    logic [GAP_W-1:0]    gap_cnt   = '0;
    logic [3:0]          stage_idx = '0;
    logic [N_STAGES-1:0] rst_q     = '1;
    logic                ready_q   = 1'b0;
    logic [1:0]          cause_q   = CAUSE_POR;

    seq_state_t          state_n;
    logic [CNT_W-1:0]    hold_cnt_n;
    logic [GAP_W-1:0]    gap_cnt_n;
    logic [3:0]          stage_idx_n;
    logic [N_STAGES-1:0] rst_n_v;
    logic                ready_n;
    logic [1:0]          cause_n;

    logic req_accept;
    logic wdt_bite;

    assign rst_out   = rst_q;
    assign ready     = ready_q;
    assign rst_cause = cause_q;

    reset_sync_debounce #(
        .DEB_W(DEB_W)
    ) u_req (
        .clk    (clk),
        .reset  (reset),
        .rst_req(rst_req),
        .accept (req_accept)
    );

`ifdef RESET_SEQ_WDT_EN
    localparam logic [WDT_W-1:0] WDT_LAST = '1;

    logic [WDT_W-1:0] wdt_cnt = '0;

    // A kick in the same cycle as the terminal count wins over the bite.
    assign wdt_bite = (state == RUN) && wdt_en && !wdt_kick && (wdt_cnt == WDT_LAST);

    always_ff @(posedge clk) begin
        if (reset || (state != RUN) || !wdt_en || req_accept || wdt_bite || wdt_kick) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + 1'b1;
        end
    end
`else
    logic unused_wdt;
    assign unused_wdt = wdt_en ^ wdt_kick ^ (WDT_W > 0);
    assign wdt_bite   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            stage_idx <= '0;
            rst_q     <= '1;
            ready_q   <= 1'b0;
            cause_q   <= CAUSE_POR;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_cnt_n;
            gap_cnt   <= gap_cnt_n;
            stage_idx <= stage_idx_n;
            rst_q     <= rst_n_v;
            ready_q   <= ready_n;
            cause_q   <= cause_n;
        end
    end

    always_comb begin
        state_n     = state;
        hold_cnt_n  = hold_cnt;
        gap_cnt_n   = gap_cnt;
        stage_idx_n = stage_idx;
        rst_n_v     = rst_q;
        ready_n     = ready_q;
        cause_n     = cause_q;

        case (state)
            HOLD: begin
                rst_n_v    = '1;
                ready_n    = 1'b0;
                hold_cnt_n = hold_cnt + 1'b1;
                // Stage 0 drops on the same edge that enters RELEASE.
                if (hold_cnt == HOLD_LAST) begin
                    state_n     = RELEASE;
                    rst_n_v[0]  = 1'b0;
                    gap_cnt_n   = '0;
                    stage_idx_n = 4'd1;
                end
            end
            RELEASE: begin
                if (stage_idx == STAGE_LAST) begin
                    state_n = RUN;
                    ready_n = 1'b1;
                end else if (gap_cnt == GAP_LAST) begin
                    for (int k = 1; k < N_STAGES; k++) begin
                        if (stage_idx == 4'(k)) begin
                            rst_n_v[k] = 1'b0;
                        end
                    end
                    gap_cnt_n   = '0;
                    stage_idx_n = stage_idx + 4'd1;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            RUN: begin
                ready_n = 1'b1;
            end
            default: begin
                state_n = HOLD;
            end
        endcase

        if (req_accept) begin
            state_n    = HOLD;
            hold_cnt_n = '0;
            rst_n_v    = '1;
            ready_n    = 1'b0;
            cause_n    = CAUSE_EXT;
        end else if (wdt_bite) begin
            state_n    = HOLD;
            hold_cnt_n = '0;
            rst_n_v    = '1;
            ready_n    = 1'b0;
            cause_n    = CAUSE_WDT;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed bench for reset_sequencer (watchdog steps need RESET_SEQ_WDT_EN)
module tb_reset_sequencer;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       rst_req  = 1'b0;
    logic       wdt_en   = 1'b0;
    logic       wdt_kick = 1'b0;
    logic [2:0] rst_out;
    logic       ready;
    logic [1:0] rst_cause;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    reset_sequencer #(
        .CNT_W    (4),
        .N_STAGES (3),
        .STAGE_GAP(4),
        .DEB_W    (2),
        .WDT_W    (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rst_req  (rst_req),
        .wdt_en   (wdt_en),
        .wdt_kick (wdt_kick),
        .rst_out  (rst_out),
        .ready    (ready),
        .rst_cause(rst_cause)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic goto(input int c);
        if (c > cyc) begin
            repeat (c - cyc) @(posedge clk);
            #1;
            cyc = c;
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        check({tag, "_rst_out"}, 32'(rst_out), 32'h7);
        check({tag, "_ready"}, 32'(ready), 32'h0);
        check({tag, "_cause"}, 32'(rst_cause), 32'h0);
    endtask

    task automatic run_sequence(input string tag);
        goto(15); check({tag, "_c15"}, 32'({ready, rst_out}), 32'h7);
        goto(16); check({tag, "_c16"}, 32'({ready, rst_out}), 32'h6);
        goto(19); check({tag, "_c19"}, 32'({ready, rst_out}), 32'h6);
        goto(20); check({tag, "_c20"}, 32'({ready, rst_out}), 32'h4);
        goto(23); check({tag, "_c23"}, 32'({ready, rst_out}), 32'h4);
        goto(24); check({tag, "_c24"}, 32'({ready, rst_out}), 32'h0);
        goto(25); check({tag, "_c25"}, 32'({ready, rst_out}), 32'h8);
    endtask

    initial begin
        #1;
        check("por_rst_out", 32'(rst_out), 32'h7);
        check("por_ready", 32'(ready), 32'h0);
        check("por_cause", 32'(rst_cause), 32'h0);
        run_sequence("por");
        check("por_cause_run", 32'(rst_cause), 32'h0);

        goto(40);
        do_reset("rst_run");
        run_sequence("rst_seq");

        rst_req = 1'b1;
        goto(cyc + 3);
        rst_req = 1'b0;
        goto(cyc + 12);
        check("glitch_out", 32'({ready, rst_out}), 32'h8);
        check("glitch_cause", 32'(rst_cause), 32'h0);

        rst_req = 1'b1;
        goto(cyc + 6);
        check("req_pending", 32'(rst_out), 32'h0);
        goto(cyc + 1);
        check("req_out", 32'({ready, rst_out}), 32'h7);
        check("req_cause", 32'(rst_cause), 32'h1);
        cyc = 0;
        goto(3);
        rst_req = 1'b0;
        run_sequence("req_seq");
        goto(80);
        check("req_once", 32'({ready, rst_out}), 32'h8);

        do_reset("mid_pre");
        goto(12);
        rst_req = 1'b1;
        goto(18);
        check("mid_c18", 32'(rst_out), 32'h6);
        goto(19);
        check("mid_out", 32'(rst_out), 32'h7);
        check("mid_cause", 32'(rst_cause), 32'h1);
        cyc = 0;
        goto(5);
        rst_req = 1'b0;
        run_sequence("mid_seq");

`ifdef RESET_SEQ_WDT_EN
        wdt_en = 1'b1;
        do_reset("wdt_pre");
        goto(88);
        check("wdt_c88", 32'({ready, rst_out}), 32'h8);
        goto(89);
        check("wdt_bite", 32'({ready, rst_out}), 32'h7);
        check("wdt_cause", 32'(rst_cause), 32'h2);
        cyc = 0;
        goto(25);
        for (int i = 0; i < 20; i++) begin
            goto(cyc + 49);
            check("kick_run", 32'({ready, rst_out}), 32'h8);
            wdt_kick = 1'b1;
            goto(cyc + 1);
            wdt_kick = 1'b0;
        end
        goto(cyc + 63);
        wdt_kick = 1'b1;
        goto(cyc + 1);
        wdt_kick = 1'b0;
        check("kick_vs_bite", 32'({ready, rst_out}), 32'h8);
        goto(cyc + 57);
        rst_req = 1'b1;
        goto(cyc + 6);
        check("req_vs_bite_pre", 32'(rst_out), 32'h0);
        goto(cyc + 1);
        check("req_vs_bite_out", 32'(rst_out), 32'h7);
        check("req_vs_bite_cause", 32'(rst_cause), 32'h1);
        cyc = 0;
        goto(4);
        rst_req = 1'b0;
        wdt_en = 1'b0;
        run_sequence("after_both");
`else
        wdt_en = 1'b1;
        do_reset("nowdt_pre");
        run_sequence("nowdt_seq");
        for (int i = 0; i < 8; i++) begin
            goto(cyc + 25);
            check("nowdt_run", 32'({ready, rst_out}), 32'h8);
        end
        check("nowdt_cause", 32'(rst_cause), 32'h0);
        wdt_en = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
